// File: rtl/bridge_interco_pkg.sv
// Shared types and sizing helpers for the bridge interconnect response path.
package bridge_interco_pkg;

  localparam int N_SLAVE_DEFAULT = 16;

  typedef logic [N_SLAVE_DEFAULT-1:0] dest_t;

  // Pointer width is kept at least 1 bit so a depth-1 FIFO still has a legal pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bridge_dest_fifo.sv
// In-order tracking FIFO of one-hot slave destinations for outstanding requests.
module bridge_dest_fifo
  import bridge_interco_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset: entries are only visible while count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Explicit wrap compare keeps non-power-of-two depths correct.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bridge_resp_decoder.sv
// Routes slave responses back to one master strictly in request order, flagging stray responses.
module bridge_resp_decoder
  import bridge_interco_pkg::*;
#(
  parameter int N_SLAVE         = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          data_req_i,
  input  logic                          data_gnt_i,
  input  logic [N_SLAVE-1:0]            destination_i,
  input  logic [N_SLAVE-1:0]            data_r_valid_i,
  input  logic [N_SLAVE*DATA_WIDTH-1:0] data_r_rdata_i,
  input  logic [N_SLAVE-1:0]            data_r_opc_i,
  output logic                          data_r_valid_o,
  output logic [DATA_WIDTH-1:0]         data_r_rdata_o,
  output logic                          data_r_opc_o,
  output logic                          outstanding_full_o,
  input  logic                          err_clr_i,
  output logic                          err_unexpected_o
);

  logic               push_req;
  logic               hit;
  logic               err_set;
  logic               fifo_full;
  logic               fifo_empty;
  logic [N_SLAVE-1:0] head_dest;

  assign push_req = data_req_i & data_gnt_i;

  bridge_dest_fifo #(
    .WIDTH (N_SLAVE),
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .din   (destination_i),
    .pop   (hit),
    .head  (head_dest),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign hit                = ~fifo_empty & (|(data_r_valid_i & head_dest));
  assign data_r_valid_o     = hit;
  assign outstanding_full_o = fifo_full;

  // AND-OR mux: a non-one-hot head ORs every selected slave together.
  always_comb begin
    data_r_rdata_o = '0;
    data_r_opc_o   = 1'b0;
    for (int k = 0; k < N_SLAVE; k++) begin
      if (hit && head_dest[k]) begin
        data_r_rdata_o = data_r_rdata_o | data_r_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        data_r_opc_o   = data_r_opc_o | data_r_opc_i[k];
      end
    end
  end

  // Empty is registered state, so a response in the same cycle as the first push is stray.
  assign err_set = (push_req & fifo_full)
                 | (fifo_empty & (|data_r_valid_i))
                 | (~fifo_empty & (|(data_r_valid_i & ~head_dest)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         err_unexpected_o <= 1'b0;
    else if (err_set)   err_unexpected_o <= 1'b1;
    else if (err_clr_i) err_unexpected_o <= 1'b0;
  end

endmodule

// File: tb/tb_bridge_resp_decoder.sv
// Directed bench: depth-4 instance for ordering/fill/error cases, depth-3 instance for pointer wrap.
module tb_bridge_resp_decoder;

  localparam int NS = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               req, gnt, err_clr;
  logic [NS-1:0]      dest, rv, opc_in;
  logic [NS*DW-1:0]   rdata;
  logic               valid_o, opc_o, full_o, err_o;
  logic [DW-1:0]      rdata_o;

  logic               req3, gnt3, err_clr3;
  logic [NS-1:0]      dest3, rv3, opc_in3;
  logic [NS*DW-1:0]   rdata3;
  logic               valid3_o, opc3_o, full3_o, err3_o;
  logic [DW-1:0]      rdata3_o;

  int passed = 0;
  int total  = 0;

  bridge_resp_decoder #(.N_SLAVE(NS), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_req_i(req), .data_gnt_i(gnt), .destination_i(dest),
    .data_r_valid_i(rv), .data_r_rdata_i(rdata), .data_r_opc_i(opc_in),
    .data_r_valid_o(valid_o), .data_r_rdata_o(rdata_o), .data_r_opc_o(opc_o),
    .outstanding_full_o(full_o), .err_clr_i(err_clr), .err_unexpected_o(err_o)
  );

  bridge_resp_decoder #(.N_SLAVE(NS), .DATA_WIDTH(DW), .MAX_OUTSTANDING(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .data_req_i(req3), .data_gnt_i(gnt3), .destination_i(dest3),
    .data_r_valid_i(rv3), .data_r_rdata_i(rdata3), .data_r_opc_i(opc_in3),
    .data_r_valid_o(valid3_o), .data_r_rdata_o(rdata3_o), .data_r_opc_o(opc3_o),
    .outstanding_full_o(full3_o), .err_clr_i(err_clr3), .err_unexpected_o(err3_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = 0; gnt = 0; dest = '0; rv = '0; opc_in = '0; err_clr = 0;
    req3 = 0; gnt3 = 0; dest3 = '0; rv3 = '0; opc_in3 = '0; err_clr3 = 0;
    for (int k = 0; k < NS; k++) begin
      rdata[k*DW +: DW]  = 32'h5A5A_0000 | 32'(k);
      rdata3[k*DW +: DW] = 32'hA5A5_0000 | 32'(k);
    end
  endtask

  task automatic clear_err();
    err_clr = 1; step(); err_clr = 0;
  endtask

  function automatic logic [NS-1:0] ddest(input int i);
    logic [NS-1:0] one;
    one = 16'h0001;
    return one << ((i * 5) % 16);
  endfunction

  function automatic logic [DW-1:0] dval(input int i);
    return 32'hD000_0000 + 32'(i * 17);
  endfunction

  task automatic test_reset();
    idle();
    rst_n = 0;
    #2;
    total++; if (valid_o !== 1'b0) $display("FAIL reset_valid got=%0h exp=0", valid_o); else passed++;
    total++; if (rdata_o !== 32'h0) $display("FAIL reset_rdata got=%0h exp=0", rdata_o); else passed++;
    total++; if (opc_o !== 1'b0) $display("FAIL reset_opc got=%0h exp=0", opc_o); else passed++;
    total++; if (full_o !== 1'b0) $display("FAIL reset_full got=%0h exp=0", full_o); else passed++;
    total++; if (err_o !== 1'b0) $display("FAIL reset_err got=%0h exp=0", err_o); else passed++;
    total++; if (full3_o !== 1'b0) $display("FAIL reset_full3 got=%0h exp=0", full3_o); else passed++;
    step(); rst_n = 1; step();
  endtask

  task automatic test_single();
    idle();
    req = 1; gnt = 1; dest = 16'h0004;
    step();
    req = 0; gnt = 0; dest = '0;
    rv = 16'h0004; opc_in = 16'h0004; rdata[2*DW +: DW] = 32'hCAFE_0001;
    #1;
    total++; if (valid_o !== 1'b1) $display("FAIL single_valid got=%0h exp=1", valid_o); else passed++;
    total++; if (rdata_o !== 32'hCAFE_0001) $display("FAIL single_rdata got=%0h exp=cafe0001", rdata_o); else passed++;
    total++; if (opc_o !== 1'b1) $display("FAIL single_opc got=%0h exp=1", opc_o); else passed++;
    step();
    rv = '0; opc_in = '0;
    total++; if (err_o !== 1'b0) $display("FAIL single_err got=%0h exp=0", err_o); else passed++;
    rv = 16'h0004;
    #1;
    total++; if (valid_o !== 1'b0) $display("FAIL single_empty_probe got=%0h exp=0", valid_o); else passed++;
    step();
    rv = '0;
    total++; if (err_o !== 1'b1) $display("FAIL single_probe_err got=%0h exp=1", err_o); else passed++;
    clear_err();
    total++; if (err_o !== 1'b0) $display("FAIL single_clr got=%0h exp=0", err_o); else passed++;
  endtask

  task automatic test_ordering();
    idle();
    req = 1; gnt = 1; dest = 16'h0001; step();
    dest = 16'h0002; step();
    req = 0; gnt = 0; dest = '0;
    rdata[0 +: DW] = 32'h1111_0001; rdata[DW +: DW] = 32'h2222_0001;
    rv = 16'h0002;
    #1;
    total++; if (valid_o !== 1'b0) $display("FAIL order_stray_valid got=%0h exp=0", valid_o); else passed++;
    total++; if (rdata_o !== 32'h0) $display("FAIL order_stray_rdata got=%0h exp=0", rdata_o); else passed++;
    step();
    total++; if (err_o !== 1'b1) $display("FAIL order_err got=%0h exp=1", err_o); else passed++;
    rv = 16'h0001;
    #1;
    total++; if (valid_o !== 1'b1) $display("FAIL order_s0_valid got=%0h exp=1", valid_o); else passed++;
    total++; if (rdata_o !== 32'h1111_0001) $display("FAIL order_s0_rdata got=%0h exp=11110001", rdata_o); else passed++;
    step();
    rv = 16'h0002;
    #1;
    total++; if (valid_o !== 1'b1) $display("FAIL order_s1_valid got=%0h exp=1", valid_o); else passed++;
    total++; if (rdata_o !== 32'h2222_0001) $display("FAIL order_s1_rdata got=%0h exp=22220001", rdata_o); else passed++;
    step();
    rv = '0;
    clear_err();
    total++; if (err_o !== 1'b0) $display("FAIL order_clr got=%0h exp=0", err_o); else passed++;
  endtask

  task automatic test_fill();
    logic [NS-1:0] d;
    idle();
    req = 1; gnt = 1;
    for (int i = 0; i < 4; i++) begin
      d = 16'h0001 << i;
      dest = d;
      total++; if (full_o !== 1'b0) $display("FAIL fill_notfull_%0d got=%0h exp=0", i, full_o); else passed++;
      step();
    end
    total++; if (full_o !== 1'b1) $display("FAIL fill_full got=%0h exp=1", full_o); else passed++;
    total++; if (err_o !== 1'b0) $display("FAIL fill_err0 got=%0h exp=0", err_o); else passed++;
    dest = 16'h0010;
    step();
    req = 0; gnt = 0;
    total++; if (full_o !== 1'b1) $display("FAIL fill_5th_full got=%0h exp=1", full_o); else passed++;
    total++; if (err_o !== 1'b1) $display("FAIL fill_5th_err got=%0h exp=1", err_o); else passed++;
    clear_err();
    req = 1; gnt = 1; dest = 16'h0020;
    rv = 16'h0001; rdata[0 +: DW] = 32'h0F11_0000;
    #1;
    total++; if (valid_o !== 1'b1) $display("FAIL fill_pop_valid got=%0h exp=1", valid_o); else passed++;
    total++; if (rdata_o !== 32'h0F11_0000) $display("FAIL fill_pop_rdata got=%0h exp=0f110000", rdata_o); else passed++;
    step();
    req = 0; gnt = 0; dest = '0; rv = '0;
    total++; if (full_o !== 1'b0) $display("FAIL fill_after_pop_full got=%0h exp=0", full_o); else passed++;
    total++; if (err_o !== 1'b1) $display("FAIL fill_blocked_err got=%0h exp=1", err_o); else passed++;
    for (int i = 1; i < 4; i++) begin
      d = 16'h0001 << i;
      rv = d;
      rdata[i*DW +: DW] = 32'h0F00_0000 | 32'(i);
      #1;
      total++; if (valid_o !== 1'b1) $display("FAIL fill_drain_valid_%0d got=%0h exp=1", i, valid_o); else passed++;
      total++; if (rdata_o !== (32'h0F00_0000 | 32'(i))) $display("FAIL fill_drain_rdata_%0d got=%0h exp=%0h", i, rdata_o, 32'h0F00_0000 | 32'(i)); else passed++;
      step();
    end
    rv = 16'h0020;
    #1;
    total++; if (valid_o !== 1'b0) $display("FAIL fill_blocked_entry got=%0h exp=0", valid_o); else passed++;
    step();
    rv = '0;
    clear_err();
  endtask

  task automatic test_empty();
    idle();
    rv = 16'h8000; opc_in = 16'h8000; rdata[15*DW +: DW] = 32'hFFFF_FFFF;
    #1;
    total++; if (valid_o !== 1'b0) $display("FAIL empty_valid got=%0h exp=0", valid_o); else passed++;
    total++; if (rdata_o !== 32'h0) $display("FAIL empty_rdata got=%0h exp=0", rdata_o); else passed++;
    total++; if (opc_o !== 1'b0) $display("FAIL empty_opc got=%0h exp=0", opc_o); else passed++;
    step();
    total++; if (err_o !== 1'b1) $display("FAIL empty_err got=%0h exp=1", err_o); else passed++;
    err_clr = 1;
    step();
    total++; if (err_o !== 1'b1) $display("FAIL empty_set_wins got=%0h exp=1", err_o); else passed++;
    rv = '0; opc_in = '0;
    step();
    err_clr = 0;
    total++; if (err_o !== 1'b0) $display("FAIL empty_clr got=%0h exp=0", err_o); else passed++;
  endtask

  task automatic test_non_onehot();
    idle();
    req = 1; gnt = 1; dest = 16'h0003;
    step();
    req = 0; gnt = 0; dest = '0;
    rv = 16'h0001; opc_in = 16'h0002;
    rdata[0 +: DW] = 32'h0000_00F0; rdata[DW +: DW] = 32'h0000_000F;
    #1;
    total++; if (valid_o !== 1'b1) $display("FAIL multi_valid got=%0h exp=1", valid_o); else passed++;
    total++; if (rdata_o !== 32'h0000_00FF) $display("FAIL multi_rdata got=%0h exp=ff", rdata_o); else passed++;
    total++; if (opc_o !== 1'b1) $display("FAIL multi_opc got=%0h exp=1", opc_o); else passed++;
    step();
    rv = '0; opc_in = '0;
    total++; if (err_o !== 1'b0) $display("FAIL multi_err got=%0h exp=0", err_o); else passed++;
  endtask

  task automatic test_wrap();
    int r;
    int k;
    idle();
    req3 = 1; gnt3 = 1;
    dest3 = ddest(0); step();
    dest3 = ddest(1); step();
    r = 0;
    for (int i = 2; i < 12; i++) begin
      dest3 = ddest(i);
      k = (r * 5) % 16;
      rv3 = ddest(r);
      rdata3[k*DW +: DW] = dval(r);
      #1;
      total++; if (valid3_o !== 1'b1) $display("FAIL wrap_valid_%0d got=%0h exp=1", r, valid3_o); else passed++;
      total++; if (rdata3_o !== dval(r)) $display("FAIL wrap_rdata_%0d got=%0h exp=%0h", r, rdata3_o, dval(r)); else passed++;
      total++; if (full3_o !== 1'b0) $display("FAIL wrap_full_%0d got=%0h exp=0", r, full3_o); else passed++;
      step();
      r++;
    end
    req3 = 0; gnt3 = 0; dest3 = '0;
    for (int j = 0; j < 2; j++) begin
      k = (r * 5) % 16;
      rv3 = ddest(r);
      rdata3[k*DW +: DW] = dval(r);
      #1;
      total++; if (rdata3_o !== dval(r)) $display("FAIL wrap_drain_%0d got=%0h exp=%0h", r, rdata3_o, dval(r)); else passed++;
      step();
      r++;
    end
    rv3 = '0;
    req3 = 1; gnt3 = 1;
    for (int i = 12; i < 15; i++) begin
      dest3 = ddest(i);
      step();
    end
    req3 = 0; gnt3 = 0; dest3 = '0;
    total++; if (full3_o !== 1'b1) $display("FAIL wrap_full3 got=%0h exp=1", full3_o); else passed++;
    for (int i = 12; i < 15; i++) begin
      k = (i * 5) % 16;
      rv3 = ddest(i);
      rdata3[k*DW +: DW] = dval(i);
      #1;
      total++; if (rdata3_o !== dval(i)) $display("FAIL wrap_final_%0d got=%0h exp=%0h", i, rdata3_o, dval(i)); else passed++;
      step();
    end
    rv3 = '0;
    total++; if (err3_o !== 1'b0) $display("FAIL wrap_err got=%0h exp=0", err3_o); else passed++;
  endtask

  task automatic test_reset_mid();
    idle();
    req = 1; gnt = 1; dest = 16'h0001; step();
    dest = 16'h0002; step();
    req = 0; gnt = 0; dest = '0;
    rv = 16'h0001; rdata[0 +: DW] = 32'hBEEF_0001;
    #1;
    total++; if (valid_o !== 1'b1) $display("FAIL rstmid_pre_valid got=%0h exp=1", valid_o); else passed++;
    #1;
    rst_n = 0;
    #1;
    total++; if (valid_o !== 1'b0) $display("FAIL rstmid_valid got=%0h exp=0", valid_o); else passed++;
    total++; if (rdata_o !== 32'h0) $display("FAIL rstmid_rdata got=%0h exp=0", rdata_o); else passed++;
    total++; if (full_o !== 1'b0) $display("FAIL rstmid_full got=%0h exp=0", full_o); else passed++;
    step();
    rst_n = 1;
    step();
    total++; if (err_o !== 1'b1) $display("FAIL rstmid_late_err got=%0h exp=1", err_o); else passed++;
    rv = '0;
    clear_err();
    total++; if (err_o !== 1'b0) $display("FAIL rstmid_clr got=%0h exp=0", err_o); else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_ordering();
    test_fill();
    test_empty();
    test_non_onehot();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
